// File: rtl/dram_port_scheduler.sv
// Arbitrates one write and one read requester onto a single DRAM command port, one burst at a time.
// Grants are combinational in IDLE; write beats stall on DRAM_Wait_Request and read beats follow DRAM_Read_Data_Valid.
module dram_port_scheduler #(
  parameter int WR_WEIGHT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [24:0]  wr_addr,
  input  logic [4:0]   wr_burst_count,
  input  logic [255:0] wr_data,
  input  logic         wr_data_valid,
  output logic         wr_grant,
  output logic         wr_data_ack,
  input  logic         rd_req,
  input  logic [24:0]  rd_addr,
  input  logic [4:0]   rd_burst_count,
  output logic         rd_grant,
  output logic [255:0] rd_data,
  output logic         rd_data_valid,
  input  logic         DRAM_Wait_Request,
  output logic         DRAM_Write_Enable,
  output logic         DRAM_Write_Burst_Begin,
  output logic         DRAM_Read_Enable,
  output logic [4:0]   DRAM_Burst_Count,
  output logic [24:0]  DRAM_Addr,
  output logic [255:0] DRAM_Write_Data,
  input  logic [255:0] DRAM_Read_Data,
  input  logic         DRAM_Read_Data_Valid,
  output logic         err_stray_rdvalid
);

  localparam int CW = ($clog2(WR_WEIGHT + 1) > 3) ? $clog2(WR_WEIGHT + 1) : 3;
  localparam logic [CW-1:0] WW = CW'(WR_WEIGHT);

  typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT, TURN} state_e;

  state_e          state_q, state_d;
  logic [24:0]     addr_q, addr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      beat_q, beat_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            err_q, err_d;
  logic            pick_wr, pick_rd, wr_accept, last_beat;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    consec_d  = consec_q;
    err_d     = err_q;

    wr_grant               = 1'b0;
    rd_grant               = 1'b0;
    wr_data_ack            = 1'b0;
    rd_data                = '0;
    rd_data_valid          = 1'b0;
    DRAM_Write_Enable      = 1'b0;
    DRAM_Write_Burst_Begin = 1'b0;
    DRAM_Read_Enable       = 1'b0;
    DRAM_Burst_Count       = '0;
    DRAM_Addr              = '0;
    DRAM_Write_Data        = '0;
    err_stray_rdvalid      = err_q;

    // Writes win ties until they have starved a waiting read WR_WEIGHT times.
    pick_wr   = wr_req && (!rd_req || consec_q != WW);
    pick_rd   = rd_req && !pick_wr;
    wr_accept = 1'b0;
    last_beat = (beat_q == cnt_q - 5'd1);

    case (state_q)
      IDLE: begin
        if (pick_wr) begin
          wr_grant = 1'b1;
          addr_d   = wr_addr;
          cnt_d    = (wr_burst_count == 5'd0) ? 5'd1 : wr_burst_count;
          beat_d   = '0;
          state_d  = WR_BURST;
          if (rd_req && consec_q != WW) consec_d = consec_q + CW'(1);
        end else if (pick_rd) begin
          rd_grant = 1'b1;
          addr_d   = rd_addr;
          cnt_d    = (rd_burst_count == 5'd0) ? 5'd1 : rd_burst_count;
          beat_d   = '0;
          consec_d = '0;
          state_d  = RD_CMD;
        end
      end
      WR_BURST: begin
        DRAM_Write_Enable      = wr_data_valid;
        DRAM_Write_Burst_Begin = wr_data_valid && (beat_q == 5'd0);
        DRAM_Write_Data        = wr_data;
        DRAM_Addr              = addr_q;
        DRAM_Burst_Count       = cnt_q;
        wr_accept              = wr_data_valid && !DRAM_Wait_Request;
        wr_data_ack            = wr_accept;
        if (wr_accept) begin
          beat_d = last_beat ? 5'd0 : beat_q + 5'd1;
          if (last_beat) state_d = IDLE;
        end
      end
      RD_CMD: begin
        DRAM_Read_Enable = 1'b1;
        DRAM_Addr        = addr_q;
        DRAM_Burst_Count = cnt_q;
        if (!DRAM_Wait_Request) begin
          beat_d  = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rd_data       = DRAM_Read_Data;
        rd_data_valid = DRAM_Read_Data_Valid;
        if (DRAM_Read_Data_Valid) begin
          beat_d = last_beat ? 5'd0 : beat_q + 5'd1;
          if (last_beat) state_d = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data with no read in flight has nowhere to go; drop it and remember.
    if (DRAM_Read_Data_Valid && state_q != RD_WAIT) err_d = 1'b1;

    if (rst) begin
      wr_grant               = 1'b0;
      rd_grant               = 1'b0;
      wr_data_ack            = 1'b0;
      rd_data                = '0;
      rd_data_valid          = 1'b0;
      DRAM_Write_Enable      = 1'b0;
      DRAM_Write_Burst_Begin = 1'b0;
      DRAM_Read_Enable       = 1'b0;
      DRAM_Burst_Count       = '0;
      DRAM_Addr              = '0;
      DRAM_Write_Data        = '0;
      err_stray_rdvalid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      consec_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      consec_q <= consec_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/dram_port_scheduler.md
DRAM_PORT_SCHEDULER -- requirements
Module: dram_port_scheduler

Interface
REQ-001 SHALL have parameter WR_WEIGHT, default 4: max consecutive write bursts granted while a read is pending.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: wr_req  in  1  write requester holds high until wr_grant; wr_addr  in  25  {1'b0, board[2:0], channel[6:0], offset[13:0]}; wr_burst_count  in  5  beats.
REQ-005 SHALL have ports: wr_data  in  256; wr_data_valid  in  1; wr_grant  out  1  one-cycle pulse; wr_data_ack  out  1  beat accepted by DRAM.
REQ-006 SHALL have ports: rd_req  in  1; rd_addr  in  25; rd_burst_count  in  5; rd_grant  out  1  one-cycle pulse; rd_data  out  256; rd_data_valid  out  1.
REQ-007 SHALL have ports: DRAM_Wait_Request  in  1  high = stall; DRAM_Write_Enable, DRAM_Write_Burst_Begin, DRAM_Read_Enable  out  1; DRAM_Burst_Count  out  5; DRAM_Addr  out  25; DRAM_Write_Data  out  256.
REQ-008 SHALL have ports: DRAM_Read_Data  in  256; DRAM_Read_Data_Valid  in  1; err_stray_rdvalid  out  1  sticky.

Function
REQ-009 SHALL implement states IDLE, WR_BURST, RD_CMD, RD_WAIT, TURN.
REQ-010 IDLE: only wr_req -> grant write; only rd_req -> grant read; both -> write, unless consec_wr == WR_WEIGHT, then read.
REQ-011 Grant cycle SHALL pulse wr_grant/rd_grant, latch addr and burst count into internal registers, next state WR_BURST/RD_CMD.
REQ-012 Latched burst count 0 SHALL be coerced to 1.
REQ-013 consec_wr (3+ bits, saturating at WR_WEIGHT) SHALL increment on write grant when rd_req high, clear on read grant, hold otherwise.
REQ-014 WR_BURST: DRAM_Write_Enable = wr_data_valid; DRAM_Write_Data = wr_data; DRAM_Addr/DRAM_Burst_Count = latched values.
REQ-015 Beat accepted when DRAM_Write_Enable && !DRAM_Wait_Request; wr_data_ack high that same cycle; beat counter +1.
REQ-016 DRAM_Write_Burst_Begin SHALL be high only while the first beat is presented, held across stall cycles until that beat is accepted.
REQ-017 On acceptance of the last beat, WR_BURST -> IDLE (no bubble between write bursts).
REQ-018 RD_CMD: DRAM_Read_Enable=1 with latched addr/count held until !DRAM_Wait_Request, then -> RD_WAIT.
REQ-019 RD_WAIT: rd_data = DRAM_Read_Data; rd_data_valid = DRAM_Read_Data_Valid; count beats; after last beat -> TURN.
REQ-020 TURN: one idle cycle, all DRAM strobes low, -> IDLE.
REQ-021 DRAM_Read_Data_Valid outside RD_WAIT SHALL be dropped (rd_data_valid 0) and SHALL set err_stray_rdvalid until reset.
REQ-022 Requests arriving outside IDLE SHALL wait; grants only in IDLE; at most one burst outstanding.
REQ-023 All DRAM strobes, wr_data_ack, and rd_data_valid SHALL be 0 in IDLE and TURN.

Reset
REQ-024 rst SHALL force IDLE, beat counters 0, consec_wr 0, latched addr/count 0, err_stray_rdvalid 0.
REQ-025 Under reset, all outputs SHALL be 0, including mid-burst; an interrupted burst is abandoned and not resumed.

Verification
REQ-026 wr_req only, addr 25'h0123456, count 4, Wait_Request low, data valid every cycle -> grant pulse, 4 writes on consecutive cycles, Burst_Begin on beat 0 only, IDLE 1 cycle later.
REQ-027 Write count 2, Wait_Request high 3 cycles on beat 0 -> Burst_Begin and data held 4 cycles; wr_data_ack exactly twice.
REQ-028 rd_req, count 8, Read_Data_Valid after 5-cycle latency -> 8 rd_data_valid pulses, then TURN, then IDLE.
REQ-029 Both requesters held continuously, WR_WEIGHT=4 -> grant order W,W,W,W,R,W,W,W,W,R.
REQ-030 Read_Data_Valid pulsed in IDLE -> rd_data_valid stays 0, err_stray_rdvalid 1 until rst.
REQ-031 rst asserted on beat 2 of an 8-beat write -> next cycle all outputs 0, state IDLE; wr_req high afterwards is granted as a fresh burst.
